// File: rtl/z16_loader_pkg.sv
// Shared types and constants for the Z16 serial program loader.
package z16_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DLO,
      S_DHI,
      S_CHK,
      S_ERR
   } state_t;

   localparam logic [7:0] MAGIC_DEF      = 8'hA5;
   localparam int         BYTES_PER_WORD = 2;
   localparam int         HDR_BYTES      = 2;   // MAGIC + LEN

endpackage

// File: rtl/z16_loader_timeout.sv
// Inter-byte idle counter; expire holds once the count reaches TIMEOUT_CYC.
module z16_loader_timeout #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   assign expire = (cnt == CW'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !expire)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/z16_prog_loader.sv
// Framed byte stream -> little-endian 16-bit words into instruction RAM,
// holding the Z16 core in reset while an image is being transferred.
module z16_prog_loader
   import z16_loader_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter logic [7:0]  MAGIC       = MAGIC_DEF,
   parameter int          TIMEOUT_CYC = 100000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   output logic              o_rx_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [15:0]       o_wdata,
   output logic              o_cpu_rst,
   output logic              o_done,
   output logic              o_err
);

   state_t            state;
   logic [7:0]        len;
   logic [7:0]        words;
   logic [7:0]        lo;
   logic [7:0]        sum;
   logic [ADDR_W-1:0] addr;
   logic              accept;
   logic              in_frame;
   logic              expire;

   assign accept   = i_rx_valid && o_rx_ready;
   assign in_frame = (state == S_LEN) || (state == S_DLO) ||
                     (state == S_DHI) || (state == S_CHK);

   z16_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk    (i_clk),
      .rst    (i_rst),
      .clr    (accept || !in_frame),
      .en     (in_frame),
      .expire (expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         len        <= '0;
         words      <= '0;
         lo         <= '0;
         sum        <= '0;
         addr       <= '0;
         o_rx_ready <= 1'b1;
         o_we       <= 1'b0;
         o_waddr    <= '0;
         o_wdata    <= '0;
         o_cpu_rst  <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_we       <= 1'b0;
         o_done     <= 1'b0;
         o_rx_ready <= 1'b1;
         // A stalled frame aborts even if a byte lands on the expiry cycle.
         if (expire) begin
            state <= S_ERR;
            o_err <= 1'b1;
         end else if (accept) begin
            unique case (state)
               S_IDLE, S_ERR: begin
                  if (i_rx_data == MAGIC) begin
                     state     <= S_LEN;
                     o_cpu_rst <= 1'b1;
                     o_err     <= 1'b0;
                     addr      <= '0;
                     sum       <= '0;
                     words     <= '0;
                  end
               end
               S_LEN: begin
                  len <= i_rx_data;
                  if (i_rx_data == 8'd0) begin
                     state     <= S_IDLE;
                     o_cpu_rst <= 1'b0;
                  end else begin
                     state <= S_DLO;
                  end
               end
               S_DLO: begin
                  lo    <= i_rx_data;
                  sum   <= sum + i_rx_data;
                  state <= S_DHI;
               end
               S_DHI: begin
                  // Write cycle blocks the next byte so o_waddr/o_wdata stay coherent.
                  sum        <= sum + i_rx_data;
                  o_we       <= 1'b1;
                  o_wdata    <= {i_rx_data, lo};
                  o_waddr    <= addr;
                  o_rx_ready <= 1'b0;
                  addr       <= addr + ADDR_W'(1);
                  words      <= words + 8'd1;
                  state      <= ((words + 8'd1) == len) ? S_CHK : S_DLO;
               end
               S_CHK: begin
                  if (i_rx_data == sum) begin
                     state     <= S_IDLE;
                     o_done    <= 1'b1;
                     o_cpu_rst <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     o_err <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_z16_prog_loader.sv
// Directed bench for z16_prog_loader: expected RAM writes and done pulses are
// queued by the stimulus and consumed by an independent output monitor.
module tb_z16_prog_loader;

   localparam int ADDR_W = 8;
   localparam int TO     = 40;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [15:0]       wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   typedef struct {
      bit                is_done;
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;

   always #5 clk = ~clk;

   z16_prog_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(TO)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_rx_ready (rx_ready),
      .o_we       (we),
      .o_waddr    (waddr),
      .o_wdata    (wdata),
      .o_cpu_rst  (cpu_rst),
      .o_done     (done),
      .o_err      (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
      ev_t e;
      e.is_done = 1'b0; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_done();
      ev_t e;
      e.is_done = 1'b1; e.addr = '0; e.data = '0;
      exp_q.push_back(e);
   endtask

   // Returns #1 after the accepting edge, so registered effects are visible.
   task automatic send(input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      while (!rx_ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 10) chk("rx_ready_stuck", 32'(rx_ready), 32'd1);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(waddr), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("write_kind", 32'(e.is_done), 32'd0);
            chk("write_addr", 32'(waddr), 32'(e.addr));
            chk("write_data", 32'(wdata), 32'(e.data));
            chk("write_ready_low", 32'(rx_ready), 32'd0);
            chk("write_cpu_held", 32'(cpu_rst), 32'd1);
         end
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("done_kind", 32'(e.is_done), 32'd1);
            chk("done_cpu_released", 32'(cpu_rst), 32'd0);
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"},   32'(rx_ready), 32'd1);
      chk({tag, "_we"},      32'(we),       32'd0);
      chk({tag, "_waddr"},   32'(waddr),    32'd0);
      chk({tag, "_wdata"},   32'(wdata),    32'd0);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst),  32'd0);
      chk({tag, "_done"},    32'(done),     32'd0);
      chk({tag, "_err"},     32'(err),      32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      // 1) bad checksum: both words still written, then error with core held
      push_wr(8'd0, 16'h0010);
      push_wr(8'd1, 16'h0119);
      send(8'hA5); chk("t1_cpu_held", 32'(cpu_rst), 32'd1);
      send(8'h02); send(8'h10); send(8'h00); send(8'h19); send(8'h01);
      send(8'h35);
      chk("t1_err", 32'(err), 32'd1);
      chk("t1_cpu_held_err", 32'(cpu_rst), 32'd1);
      chk("t1_no_done", 32'(done), 32'd0);

      // 2) good frame from ERR; write latency and done timing checked
      push_wr(8'd0, 16'h0010);
      push_wr(8'd1, 16'h0119);
      push_done();
      send(8'hA5); chk("t2_err_cleared", 32'(err), 32'd0);
      send(8'h02); send(8'h10); send(8'h00);
      chk("t2_we_latency0", 32'(we), 32'd1);
      send(8'h19); send(8'h01);
      chk("t2_we_latency1", 32'(we), 32'd1);
      send(8'h2A);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_cpu_release", 32'(cpu_rst), 32'd0);
      @(posedge clk); #1;
      chk("t2_done_pulse", 32'(done), 32'd0);

      // 3) empty frame
      send(8'hA5); chk("t3_cpu_held", 32'(cpu_rst), 32'd1);
      send(8'h00); chk("t3_cpu_release", 32'(cpu_rst), 32'd0);
      send(8'h01); chk("t3_idle_drop", 32'(cpu_rst), 32'd0);

      // 4) timeout inside a frame, then recovery
      send(8'hA5); send(8'h01); send(8'h49);
      repeat (TO + 5) @(posedge clk);
      #1;
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_cpu_held", 32'(cpu_rst), 32'd1);
      push_wr(8'd0, 16'h1234);
      push_done();
      send(8'hA5); chk("t4_err_cleared", 32'(err), 32'd0);
      send(8'h01); send(8'h34); send(8'h12); send(8'h46);
      chk("t4_done", 32'(done), 32'd1);

      // 5) junk before MAGIC, wrapping checksum
      send(8'h00); send(8'hFF);
      chk("t5_junk_dropped", 32'(cpu_rst), 32'd0);
      push_wr(8'd0, 16'hFFFF);
      push_done();
      send(8'hA5); send(8'h01); send(8'hFF); send(8'hFF); send(8'hFE);
      chk("t5_done", 32'(done), 32'd1);

      // 6) reset mid-frame with a byte still offered
      send(8'hA5); send(8'h01); send(8'h55);
      @(negedge clk);
      rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
      @(posedge clk); #1;
      chk_reset_vals("t6");
      @(negedge clk);
      rst = 1'b0; rx_valid = 1'b0;
      send(8'hA5); chk("t6_idle_magic", 32'(cpu_rst), 32'd1);
      send(8'h00); chk("t6_empty_release", 32'(cpu_rst), 32'd0);

      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
